// File: rtl/multicycle_ctrl.sv
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Main control FSM of the multi-cycle MIPS-subset CPU.
//                Sequences the IF/ID/EX/MEM/WB steps for R-type, beq, addi,
//                slti, lw and sw. It stalls on mem_ready_i and counts
//                retired instructions.
//  Options     : ILLEGAL_TRAP_EN - unsupported opcodes trap into HALT and
//                set a sticky illegal_o flag. When this macro is undefined,
//                unsupported opcodes execute as a NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int         CNT_W     = 16,
  parameter logic [2:0] ALU_ADD   = 3'b011,
  parameter logic [2:0] ALU_RTYPE = 3'b010,
  parameter logic [2:0] ALU_SUB   = 3'b001,
  parameter logic [2:0] ALU_SLT   = 3'b111
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_src_o,
  output logic             ir_write_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       ALU_op_o,
  output logic [2:0]       state_o,
  output logic             instr_done_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic             illegal_o
);

  // State encoding is architecturally visible on state_o
  localparam logic [2:0] c_ST_IF   = 3'd0;
  localparam logic [2:0] c_ST_ID   = 3'd1;
  localparam logic [2:0] c_ST_EX   = 3'd2;
  localparam logic [2:0] c_ST_MEM  = 3'd3;
  localparam logic [2:0] c_ST_WB   = 3'd4;
  localparam logic [2:0] c_ST_HALT = 3'd7;

  localparam logic [5:0] c_OP_RTYPE = 6'd0;
  localparam logic [5:0] c_OP_BEQ   = 6'd4;
  localparam logic [5:0] c_OP_ADDI  = 6'd8;
  localparam logic [5:0] c_OP_SLTI  = 6'd10;
  localparam logic [5:0] c_OP_LW    = 6'd35;
  localparam logic [5:0] c_OP_SW    = 6'd43;

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       r_state;
  logic [5:0]       r_op_q;
  logic [CNT_W-1:0] r_instr_cnt;

  logic [2:0] w_next;
  logic       w_pc_write;
  logic       w_pc_src;
  logic       w_ir_write;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_src_a;
  logic [1:0] w_src_b;
  logic [2:0] w_alu_op;
  logic       w_done;
`ifdef ILLEGAL_TRAP_EN
  logic       r_illegal;
  logic       w_set_illegal;
`endif

  // Next-state and control decode from current state, latched opcode and handshakes
  always_comb begin
    w_next       = r_state;
    w_pc_write   = 1'b0;
    w_pc_src     = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_src_a      = 1'b0;
    w_src_b      = 2'b00;
    w_alu_op     = 3'b000;
    w_done       = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    w_set_illegal = 1'b0;
`endif
    case (r_state)
      c_ST_IF: begin
        // Fetch and PC+4 in parallel; both commit only when memory answers
        w_mem_read = 1'b1;
        w_src_b    = 2'b01;
        w_alu_op   = ALU_ADD;
        w_ir_write = mem_ready_i;
        w_pc_write = mem_ready_i;
        if (mem_ready_i) begin
          w_next = c_ST_ID;
        end
      end
      c_ST_ID: begin
        // Speculative branch target (PC + imm<<2) parked in ALUOut
        w_src_b  = 2'b11;
        w_alu_op = ALU_ADD;
        w_next   = c_ST_EX;
      end
      c_ST_EX: begin
        case (r_op_q)
          c_OP_RTYPE: begin
            w_src_a  = 1'b1;
            w_alu_op = ALU_RTYPE;
            w_next   = c_ST_WB;
          end
          c_OP_ADDI: begin
            w_src_a  = 1'b1;
            w_src_b  = 2'b10;
            w_alu_op = ALU_ADD;
            w_next   = c_ST_WB;
          end
          c_OP_SLTI: begin
            w_src_a  = 1'b1;
            w_src_b  = 2'b10;
            w_alu_op = ALU_SLT;
            w_next   = c_ST_WB;
          end
          c_OP_LW, c_OP_SW: begin
            w_src_a  = 1'b1;
            w_src_b  = 2'b10;
            w_alu_op = ALU_ADD;
            w_next   = c_ST_MEM;
          end
          c_OP_BEQ: begin
            // Compare rs-rt; take the target from ALUOut when equal
            w_src_a    = 1'b1;
            w_alu_op   = ALU_SUB;
            w_pc_src   = 1'b1;
            w_pc_write = zero_i;
            w_done     = 1'b1;
            w_next     = c_ST_IF;
          end
          default: begin
`ifdef ILLEGAL_TRAP_EN
            w_set_illegal = 1'b1;
            w_next        = c_ST_HALT;
`else
            w_done = 1'b1;
            w_next = c_ST_IF;
`endif
          end
        endcase
      end
      c_ST_MEM: begin
        // Request is held steady until the memory completes
        if (r_op_q == c_OP_LW) begin
          w_mem_read = 1'b1;
          if (mem_ready_i) begin
            w_next = c_ST_WB;
          end
        end else begin
          w_mem_write = 1'b1;
          if (mem_ready_i) begin
            w_done = 1'b1;
            w_next = c_ST_IF;
          end
        end
      end
      c_ST_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = (r_op_q == c_OP_RTYPE);
        w_mem_to_reg = (r_op_q == c_OP_LW);
        w_done       = 1'b1;
        w_next       = c_ST_IF;
      end
`ifdef ILLEGAL_TRAP_EN
      c_ST_HALT: begin
        w_next = c_ST_HALT;
      end
`endif
      default: begin
        w_next = c_ST_IF;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= c_ST_IF;
    end else begin
      r_state <= w_next;
    end
  end

  // Opcode is captured only in ID so later IR activity cannot disturb decode
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_op_q <= 6'd0;
    end else if (r_state == c_ST_ID) begin
      r_op_q <= instr_op_i;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_instr_cnt <= '0;
    end else if (w_done) begin
      r_instr_cnt <= r_instr_cnt + c_CNT_ONE;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_illegal <= 1'b0;
    end else if (w_set_illegal) begin
      r_illegal <= 1'b1;
    end
  end
  assign illegal_o = r_illegal;
`else
  assign illegal_o = 1'b0;
`endif

  // Reset forces every control strobe low without waiting for a clock
  assign pc_write_o   = rst_i & w_pc_write;
  assign pc_src_o     = rst_i & w_pc_src;
  assign ir_write_o   = rst_i & w_ir_write;
  assign mem_read_o   = rst_i & w_mem_read;
  assign mem_write_o  = rst_i & w_mem_write;
  assign reg_write_o  = rst_i & w_reg_write;
  assign reg_dst_o    = rst_i & w_reg_dst;
  assign mem_to_reg_o = rst_i & w_mem_to_reg;
  assign alu_src_a_o  = rst_i & w_src_a;
  assign alu_src_b_o  = rst_i ? w_src_b : 2'b00;
  assign ALU_op_o     = rst_i ? w_alu_op : 3'b000;
  assign instr_done_o = rst_i & w_done;
  assign state_o      = r_state;
  assign instr_cnt_o  = r_instr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Self-checking bench for multicycle_ctrl. Each instruction is
//                expanded into its expected cycle trace. The trace follows
//                the instruction's step list and stall counts. It is then
//                replayed against the DUT with randomized don't-care inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  localparam int         TB_CNT_W = 4;
  localparam logic [2:0] A_ADD    = 3'b011;
  localparam logic [2:0] A_RT     = 3'b010;
  localparam logic [2:0] A_SUB    = 3'b001;
  localparam logic [2:0] A_SLT    = 3'b111;

  logic                clk = 1'b0;
  logic                rst_i;
  logic [5:0]          instr_op_i;
  logic                zero_i;
  logic                mem_ready_i;
  logic                pc_write_o, pc_src_o, ir_write_o, mem_read_o, mem_write_o;
  logic                reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o;
  logic [1:0]          alu_src_b_o;
  logic [2:0]          ALU_op_o;
  logic [2:0]          state_o;
  logic                instr_done_o;
  logic [TB_CNT_W-1:0] instr_cnt_o;
  logic                illegal_o;
  logic [14:0]         obs_ctl;

  multicycle_ctrl #(.CNT_W(TB_CNT_W)) u_dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .instr_op_i   (instr_op_i),
    .zero_i       (zero_i),
    .mem_ready_i  (mem_ready_i),
    .pc_write_o   (pc_write_o),
    .pc_src_o     (pc_src_o),
    .ir_write_o   (ir_write_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .reg_write_o  (reg_write_o),
    .reg_dst_o    (reg_dst_o),
    .mem_to_reg_o (mem_to_reg_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .ALU_op_o     (ALU_op_o),
    .state_o      (state_o),
    .instr_done_o (instr_done_o),
    .instr_cnt_o  (instr_cnt_o),
    .illegal_o    (illegal_o)
  );

  always #5 clk = ~clk;

  assign obs_ctl = {pc_write_o, pc_src_o, ir_write_o, mem_read_o, mem_write_o,
                    reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o,
                    alu_src_b_o, ALU_op_o, instr_done_o};

  typedef struct {
    logic [2:0]  st;
    logic        rdy;
    logic        zr;
    logic [5:0]  op;
    logic        ill;
    logic [14:0] ctl;
  } cyc_t;

  cyc_t                q[$];
  int                  n_chk  = 0;
  int                  n_pass = 0;
  int                  cyc    = 0;
  logic [TB_CNT_W-1:0] exp_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [14:0] mk(input logic pcw, input logic pcs, input logic irw,
                                     input logic mr, input logic mw, input logic rw,
                                     input logic rd, input logic m2r, input logic sa,
                                     input logic [1:0] sb, input logic [2:0] alu,
                                     input logic dn);
    return {pcw, pcs, irw, mr, mw, rw, rd, m2r, sa, sb, alu, dn};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return (op == 6'd0) || (op == 6'd4) || (op == 6'd8) ||
           (op == 6'd10) || (op == 6'd35) || (op == 6'd43);
  endfunction

  task automatic push(input logic [2:0] st, input logic rdy, input logic zr,
                      input logic [5:0] op, input logic ill, input logic [14:0] ctl);
    cyc_t c;
    c.st = st; c.rdy = rdy; c.zr = zr; c.op = op; c.ill = ill; c.ctl = ctl;
    q.push_back(c);
  endtask

  // Expected trace of one instruction: nif fetch stalls, nmem memory stalls
  task automatic build(input logic [5:0] op, input logic zr, input int nif, input int nmem);
    for (int i = 0; i < nif; i++)
      push(3'd0, 1'b0, 1'($urandom), op, 1'b0, mk(0,0,0,1,0,0,0,0,0,2'b01,A_ADD,0));
    push(3'd0, 1'b1, 1'($urandom), op, 1'b0, mk(1,0,1,1,0,0,0,0,0,2'b01,A_ADD,0));
    push(3'd1, 1'($urandom), 1'($urandom), op, 1'b0, mk(0,0,0,0,0,0,0,0,0,2'b11,A_ADD,0));
    case (op)
      6'd0, 6'd8, 6'd10: begin
        push(3'd2, 1'($urandom), 1'($urandom), op, 1'b0,
             mk(0,0,0,0,0,0,0,0,1, (op == 6'd0) ? 2'b00 : 2'b10,
                (op == 6'd0) ? A_RT : (op == 6'd8) ? A_ADD : A_SLT, 0));
        push(3'd4, 1'($urandom), 1'($urandom), op, 1'b0,
             mk(0,0,0,0,0,1,(op == 6'd0),0,0,2'b00,3'b000,1));
      end
      6'd35, 6'd43: begin
        push(3'd2, 1'($urandom), 1'($urandom), op, 1'b0, mk(0,0,0,0,0,0,0,0,1,2'b10,A_ADD,0));
        for (int i = 0; i < nmem; i++)
          push(3'd3, 1'b0, 1'($urandom), op, 1'b0,
               mk(0,0,0,(op == 6'd35),(op == 6'd43),0,0,0,0,2'b00,3'b000,0));
        push(3'd3, 1'b1, 1'($urandom), op, 1'b0,
             mk(0,0,0,(op == 6'd35),(op == 6'd43),0,0,0,0,2'b00,3'b000,(op == 6'd43)));
        if (op == 6'd35)
          push(3'd4, 1'($urandom), 1'($urandom), op, 1'b0, mk(0,0,0,0,0,1,0,1,0,2'b00,3'b000,1));
      end
      6'd4: begin
        push(3'd2, 1'($urandom), zr, op, 1'b0, mk(zr,1,0,0,0,0,0,0,1,2'b00,A_SUB,1));
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        push(3'd2, 1'($urandom), 1'($urandom), op, 1'b0, 15'd0);
        for (int i = 0; i < 20; i++)
          push(3'd7, 1'($urandom), 1'($urandom), op, 1'b1, 15'd0);
`else
        push(3'd2, 1'($urandom), 1'($urandom), op, 1'b0, mk(0,0,0,0,0,0,0,0,0,2'b00,3'b000,1));
`endif
      end
    endcase
  endtask

  // Replay up to n expected cycles (n < 0: all); opcode bus is noise outside ID
  task automatic run_n(input int n);
    cyc_t c;
    int   k;
    k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      c = q.pop_front();
      @(negedge clk);
      rst_i       = 1'b1;
      mem_ready_i = c.rdy;
      zero_i      = c.zr;
      instr_op_i  = (c.st == 3'd1) ? c.op : 6'($urandom);
      #1;
      chk($sformatf("state@%0d", cyc), 32'(state_o), 32'(c.st));
      chk($sformatf("ctl@%0d", cyc), 32'(obs_ctl), 32'(c.ctl));
      chk($sformatf("cnt@%0d", cyc), 32'(instr_cnt_o), 32'(exp_cnt));
      chk($sformatf("illegal@%0d", cyc), 32'(illegal_o), 32'(c.ill));
      if (c.ctl[0]) exp_cnt = exp_cnt + 1'b1;
      cyc++;
      k++;
    end
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_ctl"}, 32'(obs_ctl), 32'd0);
    chk({tag, "_state"}, 32'(state_o), 32'd0);
    chk({tag, "_cnt"}, 32'(instr_cnt_o), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal_o), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_i       = 1'b0;
    mem_ready_i = 1'b1;
    #1 reset_chk({tag, "_a"});
    @(negedge clk);
    #1 reset_chk({tag, "_b"});
    q.delete();
    exp_cnt = '0;
  endtask

  initial begin
    logic [5:0] op;
    rst_i       = 1'b0;
    mem_ready_i = 1'b1;
    zero_i      = 1'b0;
    instr_op_i  = 6'd0;
    #1 reset_chk("por");
    repeat (2) @(negedge clk);
    reset_chk("por_hold");

    // addi from reset release, then beq taken / not taken
    build(6'd8, 1'b0, 0, 0);
    build(6'd4, 1'b1, 0, 0);
    build(6'd4, 1'b0, 0, 0);
    run_n(-1);
    // lw with two memory stalls, then R-type and slti back-to-back
    build(6'd35, 1'b0, 0, 2);
    build(6'd0, 1'b0, 0, 0);
    build(6'd10, 1'b0, 0, 0);
    run_n(-1);

    // Reset during a sw memory stall aborts it
    build(6'd43, 1'b0, 1, 4);
    run_n(5);
    do_reset("rst_sw");
    build(6'd8, 1'b0, 0, 0);
    run_n(-1);

    // Unsupported opcode 2
    build(6'd2, 1'b0, 0, 0);
    run_n(-1);
`ifdef ILLEGAL_TRAP_EN
    do_reset("rst_halt");
`endif

    // Randomized instruction stream; 4-bit counter wraps many times
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 6))
        0: op = 6'd0;
        1: op = 6'd4;
        2: op = 6'd8;
        3: op = 6'd10;
        4: op = 6'd35;
        5: op = 6'd43;
        default: begin
`ifdef ILLEGAL_TRAP_EN
          op = 6'd8;
`else
          op = 6'($urandom);
          while (is_legal(op)) op = 6'($urandom);
`endif
        end
      endcase
      build(op, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
      run_n(-1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle MIPS-subset CPU. Sequences the shared ALU, register file, PC and unified instruction/data memory through the IF/ID/EX/MEM/WB steps. Supports R-type (op 0), beq (4), addi (8), slti (10), lw (35) and sw (43). Stalls on a memory-ready handshake and counts retired instructions.

Parameters:
CNT_W, 16, width of the retired-instruction counter
ALU_ADD, 3'b011, ALU_op code for add (PC+4, branch target, address, addi)
ALU_RTYPE, 3'b010, ALU_op code that defers to the funct field
ALU_SUB, 3'b001, ALU_op code for the beq compare
ALU_SLT, 3'b111, ALU_op code for slti

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
instr_op_i  in  6  opcode field of the instruction register
zero_i  in  1  ALU zero flag
mem_ready_i  in  1  memory access completes this cycle
pc_write_o  out  1  PC load enable
pc_src_o  out  1  0 = ALU result (PC+4), 1 = ALUOut (branch target)
ir_write_o  out  1  instruction register load enable
mem_read_o  out  1  memory read request
mem_write_o  out  1  memory write request
reg_write_o  out  1  register file write enable
reg_dst_o  out  1  1 = rd, 0 = rt
mem_to_reg_o  out  1  1 = MDR, 0 = ALUOut
alu_src_a_o  out  1  0 = PC, 1 = rs
alu_src_b_o  out  2  00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
ALU_op_o  out  3  ALU control code
state_o  out  3  current state encoding
instr_done_o  out  1  one-cycle pulse on the last cycle of each instruction
instr_cnt_o  out  CNT_W  retired-instruction count
illegal_o  out  1  illegal-opcode flag; constant 0 unless ILLEGAL_TRAP_EN is defined

Behaviour:
- Reset: rst_i low sets state to IF (0), op_q to 0, instr_cnt_o to 0 and illegal_o to 0. While rst_i is low, all control outputs are forced to 0. The first IF cycle is the first rising edge after release.
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=7.
- Outputs are combinational from state, op_q, zero_i and mem_ready_i. Unlisted outputs are 0.
- IF:
  - mem_read_o=1, alu_src_a_o=0, alu_src_b_o=01, ALU_op_o=ALU_ADD.
  - ir_write_o=pc_write_o=mem_ready_i.
  - Go to ID when mem_ready_i=1, else stay in IF.
- ID:
  - Register op_q <= instr_op_i.
  - alu_src_a_o=0, alu_src_b_o=11, ALU_op_o=ALU_ADD (branch target into ALUOut).
  - Go to EX.
- EX, decoded on op_q:
  - op 0: alu_src_a_o=1, alu_src_b_o=00, ALU_op_o=ALU_RTYPE; go to WB.
  - op 8: alu_src_a_o=1, alu_src_b_o=10, ALU_op_o=ALU_ADD; go to WB.
  - op 10: alu_src_a_o=1, alu_src_b_o=10, ALU_op_o=ALU_SLT; go to WB.
  - op 35 or 43: alu_src_a_o=1, alu_src_b_o=10, ALU_op_o=ALU_ADD; go to MEM.
  - op 4: alu_src_a_o=1, alu_src_b_o=00, ALU_op_o=ALU_SUB, pc_src_o=1, pc_write_o=zero_i, instr_done_o=1; go to IF.
  - Other opcodes: no writes, instr_done_o=1; go to IF (NOP). See the Optional Feature for the alternative.
- MEM:
  - lw: mem_read_o=1; go to WB when mem_ready_i=1.
  - sw: mem_write_o=1; when mem_ready_i=1, instr_done_o=1 and go to IF.
  - Hold in MEM while mem_ready_i=0; request outputs stay asserted.
- WB:
  - reg_write_o=1, reg_dst_o=(op_q==0), mem_to_reg_o=(op_q==35).
  - instr_done_o=1; go to IF.
- Latency with mem_ready_i=1 throughout: beq/NOP 3 cycles; R-type/addi/slti/sw 4 cycles; lw 5 cycles.
- instr_cnt_o increments on every instr_done_o cycle and wraps from 2^CNT_W-1 to 0.
- op_q is written only in ID, so instr_op_i changes in other states are ignored.
- Reset asserted mid-instruction, including during a MEM stall, aborts it: no further write enables, instr_cnt_o is not incremented, and the FSM restarts at IF.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an unsupported opcode in EX sets illegal_o=1 (sticky) and moves the FSM to HALT. It does not pulse instr_done_o or increment the counter. HALT drives all control outputs 0 and is left only by reset.
- Undefined: the unsupported opcode executes as a NOP as described above. The HALT state is not built and illegal_o is tied to 0.

Test Plan:
- Reset release, mem_ready_i=1, addi (op 8) -> states 0,1,2,4. In EX: alu_src_b_o=10, ALU_op_o=011. In WB: reg_write_o=1, reg_dst_o=0. instr_cnt_o goes 0 to 1.
- beq (op 4), zero_i=1 then beq with zero_i=0 -> both take 3 cycles with pc_src_o=1 in EX. pc_write_o=1 in EX only for the first.
- lw (op 35) with mem_ready_i low for 2 MEM cycles -> stays in state 3 for 3 cycles with mem_read_o=1. WB has mem_to_reg_o=1. Total 7 cycles.
- R-type then slti back-to-back -> EX ALU_op_o=010 then 111. WB reg_dst_o=1 then 0. instr_done_o pulses twice.
- rst_i pulsed low during a sw MEM stall -> all outputs 0 immediately, counter cleared, mem_write_o never sees ready, restart in IF.
- Opcode 2 -> without macro: NOP, 3 cycles, counter +1. With ILLEGAL_TRAP_EN: state_o=7, illegal_o=1 held across 20 cycles until reset.
